// File: rtl/cva6_lsu_pkg.sv
// Shared types for the LSU issue path: the request record carried through the issue queue.
package cva6_lsu_pkg;

    localparam int LSU_ADDR_W = 32;

    typedef struct packed {
        logic [LSU_ADDR_W-1:0] instr;
        logic                  is_load;
    } lsu_req_t;

endpackage

// File: rtl/cva6_lsu_req_fifo.sv
// Small DEPTH-entry FIFO of lsu_req_t with a combinational head so the issue logic can
// pop in the same cycle it inspects the oldest entry.
module cva6_lsu_req_fifo
    import cva6_lsu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  lsu_req_t                 push_data_i,
    input  logic                     pop_i,
    output lsu_req_t                 head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    lsu_req_t               mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // No full bypass: a push while full is dropped even if a pop happens this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only the pointers define which entries are live.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i) begin
            if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/cva6_lsu_issue_queue.sv
// In-order load/store issue buffer with one outstanding load and one outstanding store.
// Optional load-after-store address hold enabled by defining LSU_ISSUE_RAW_CHECK_EN.
module cva6_lsu_issue_queue
    import cva6_lsu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [ADDR_W-1:0]        req_instr_i,
    input  logic                     req_is_load_i,
    output logic                     lsu_instr_valid_o,
    output logic [ADDR_W-1:0]        lsu_instr_o,
    output logic                     lsu_is_load_o,
    input  logic                     lsu_ready_i,
    input  logic                     load_mem_resp_i,
    input  logic                     store_mem_resp_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ld_busy_o,
    output logic                     st_busy_o,
    output logic                     err_o
);

    lsu_req_t            push_data;
    lsu_req_t            head;
    logic [ADDR_W-1:0]   head_instr;
    logic                fifo_full, fifo_empty;
    logic                issue, ld_type_ok, st_type_ok, hazard_ok;

    logic                lsu_valid_q, lsu_valid_d;
    logic [ADDR_W-1:0]   lsu_instr_q, lsu_instr_d;
    logic                lsu_is_load_q, lsu_is_load_d;
    logic                ld_busy_q, ld_busy_d;
    logic                st_busy_q, st_busy_d;
    logic                err_q, err_d;

    assign push_data.instr   = LSU_ADDR_W'(req_instr_i);
    assign push_data.is_load = req_is_load_i;
    assign head_instr        = ADDR_W'(head.instr);

    cva6_lsu_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (req_valid_i),
        .push_data_i (push_data),
        .pop_i       (issue),
        .head_o      (head),
        .count_o     (count_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

`ifdef LSU_ISSUE_RAW_CHECK_EN
    logic [ADDR_W-1:0]   st_addr_q, st_addr_d;
`endif

    // A same-cycle response releases its blocker so the next head can issue on that edge.
    always_comb begin
        ld_type_ok = !ld_busy_q || load_mem_resp_i;
        st_type_ok = !st_busy_q || store_mem_resp_i;
        hazard_ok  = 1'b1;
`ifdef LSU_ISSUE_RAW_CHECK_EN
        if (head.is_load && st_busy_q && !store_mem_resp_i && (st_addr_q == head_instr)) begin
            hazard_ok = 1'b0;
        end
`endif
        issue = !fifo_empty && lsu_ready_i && !lsu_valid_q && hazard_ok
              && (head.is_load ? ld_type_ok : st_type_ok);
    end

    always_comb begin
        lsu_valid_d   = issue;
        lsu_instr_d   = issue ? head_instr : '0;
        lsu_is_load_d = issue && head.is_load;
        ld_busy_d     = ld_busy_q;
        st_busy_d     = st_busy_q;
        err_d         = err_q;
        if (load_mem_resp_i)  ld_busy_d = 1'b0;
        if (store_mem_resp_i) st_busy_d = 1'b0;
        // Set wins over clear when a response and a same-type issue share an edge.
        if (issue && head.is_load)  ld_busy_d = 1'b1;
        if (issue && !head.is_load) st_busy_d = 1'b1;
        if ((load_mem_resp_i && !ld_busy_q) || (store_mem_resp_i && !st_busy_q)) begin
            err_d = 1'b1;
        end
    end

`ifdef LSU_ISSUE_RAW_CHECK_EN
    always_comb begin
        st_addr_d = st_addr_q;
        if (issue && !head.is_load) st_addr_d = head_instr;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) st_addr_q <= '0;
        else       st_addr_q <= st_addr_d;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lsu_valid_q   <= 1'b0;
            lsu_instr_q   <= '0;
            lsu_is_load_q <= 1'b0;
            ld_busy_q     <= 1'b0;
            st_busy_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            lsu_valid_q   <= lsu_valid_d;
            lsu_instr_q   <= lsu_instr_d;
            lsu_is_load_q <= lsu_is_load_d;
            ld_busy_q     <= ld_busy_d;
            st_busy_q     <= st_busy_d;
            err_q         <= err_d;
        end
    end

    assign req_ready_o       = !fifo_full;
    assign lsu_instr_valid_o = lsu_valid_q;
    assign lsu_instr_o       = lsu_instr_q;
    assign lsu_is_load_o     = lsu_is_load_q;
    assign ld_busy_o         = ld_busy_q;
    assign st_busy_o         = st_busy_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_cva6_lsu_issue_queue.sv
// Scoreboard bench for cva6_lsu_issue_queue: expected issues are queued at push time and
// a monitor compares every LSU pulse against the queue head.
module tb_cva6_lsu_issue_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic                clk;
    logic                rst_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [ADDR_W-1:0]   req_instr_i;
    logic                req_is_load_i;
    logic                lsu_instr_valid_o;
    logic [ADDR_W-1:0]   lsu_instr_o;
    logic                lsu_is_load_o;
    logic                lsu_ready_i;
    logic                load_mem_resp_i;
    logic                store_mem_resp_i;
    logic [CNT_W-1:0]    count_o;
    logic                ld_busy_o;
    logic                st_busy_o;
    logic                err_o;

    typedef struct {
        logic [ADDR_W-1:0] instr;
        logic              is_load;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails  = 0;

    cva6_lsu_issue_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_instr_i       (req_instr_i),
        .req_is_load_i     (req_is_load_i),
        .lsu_instr_valid_o (lsu_instr_valid_o),
        .lsu_instr_o       (lsu_instr_o),
        .lsu_is_load_o     (lsu_is_load_o),
        .lsu_ready_i       (lsu_ready_i),
        .load_mem_resp_i   (load_mem_resp_i),
        .store_mem_resp_i  (store_mem_resp_i),
        .count_o           (count_o),
        .ld_busy_o         (ld_busy_o),
        .st_busy_o         (st_busy_o),
        .err_o             (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [ADDR_W-1:0] instr, input logic is_load, input bit accept);
        exp_t e;
        req_valid_i   = 1'b1;
        req_instr_i   = instr;
        req_is_load_i = is_load;
        if (accept) begin
            e.instr   = instr;
            e.is_load = is_load;
            exp_q.push_back(e);
        end
        $display("push instr=0x%0h load=%0b expect_accept=%0b", instr, is_load, accept);
        tick();
        req_valid_i = 1'b0;
    endtask

    // Answers every outstanding request right away.
    task automatic drain(input int n);
        repeat (n) begin
            load_mem_resp_i  = ld_busy_o;
            store_mem_resp_i = st_busy_o;
            tick();
        end
        load_mem_resp_i  = 1'b0;
        store_mem_resp_i = 1'b0;
    endtask

    task automatic monitor();
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (lsu_instr_valid_o) begin
                chk("issue_not_adjacent", {31'd0, prev_valid}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", lsu_instr_o, 32'hffff_ffff);
                end else begin
                    e = exp_q.pop_front();
                    $display("issue instr=0x%0h load=%0b (expected 0x%0h load=%0b)",
                             lsu_instr_o, lsu_is_load_o, e.instr, e.is_load);
                    chk("issue_instr", lsu_instr_o, e.instr);
                    chk("issue_is_load", {31'd0, lsu_is_load_o}, {31'd0, e.is_load});
                end
            end else begin
                chk("idle_outputs_zero", lsu_instr_o | {31'd0, lsu_is_load_o}, 32'd0);
            end
            prev_valid = lsu_instr_valid_o;
        end
    endtask

    initial begin
        rst_i            = 1'b1;
        req_valid_i      = 1'b0;
        req_instr_i      = '0;
        req_is_load_i    = 1'b0;
        lsu_ready_i      = 1'b1;
        load_mem_resp_i  = 1'b0;
        store_mem_resp_i = 1'b0;

        fork
            monitor();
        join_none

        // Reset values and single load
        tick();
        tick();
        rst_i = 1'b0;
        tick();
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd1);
        chk("rst_valid", 32'(lsu_instr_valid_o), 32'd0);
        chk("rst_instr", lsu_instr_o, 32'd0);
        chk("rst_is_load", 32'(lsu_is_load_o), 32'd0);
        chk("rst_ld_busy", 32'(ld_busy_o), 32'd0);
        chk("rst_st_busy", 32'(st_busy_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);

        push_req(32'hcad, 1'b1, 1'b1);
        tick();
        chk("t1_valid", 32'(lsu_instr_valid_o), 32'd1);
        chk("t1_instr", lsu_instr_o, 32'hcad);
        chk("t1_ld_busy", 32'(ld_busy_o), 32'd1);
        tick();
        chk("t1_pulse_one_cycle", 32'(lsu_instr_valid_o), 32'd0);
        drain(2);
        chk("t1_ld_busy_clear", 32'(ld_busy_o), 32'd0);

        // Busy blocking and same-edge reissue
        push_req(32'h10, 1'b1, 1'b1);
        push_req(32'h20, 1'b1, 1'b1);
        tick();
        tick();
        chk("t2_count_held", 32'(count_o), 32'd1);
        chk("t2_ld_busy", 32'(ld_busy_o), 32'd1);
        chk("t2_blocked", 32'(lsu_instr_valid_o), 32'd0);
        load_mem_resp_i = 1'b1;
        tick();
        load_mem_resp_i = 1'b0;
        chk("t2_same_edge_valid", 32'(lsu_instr_valid_o), 32'd1);
        chk("t2_same_edge_instr", lsu_instr_o, 32'h20);
        chk("t2_count_empty", 32'(count_o), 32'd0);
        chk("t2_ld_busy_set_wins", 32'(ld_busy_o), 32'd1);
        drain(3);

        // Back-to-back spacing
        push_req(32'h40, 1'b0, 1'b1);
        push_req(32'h80, 1'b1, 1'b1);
        chk("t3_store_pulse", 32'(lsu_instr_valid_o), 32'd1);
        chk("t3_store_instr", lsu_instr_o, 32'h40);
        tick();
        chk("t3_gap", 32'(lsu_instr_valid_o), 32'd0);
        tick();
        chk("t3_load_pulse", 32'(lsu_instr_valid_o), 32'd1);
        chk("t3_load_instr", lsu_instr_o, 32'h80);
        drain(3);
        chk("t3_idle_busy", 32'({ld_busy_o, st_busy_o}), 32'd0);

        // Full and wrap-around, three rounds
        for (int r = 0; r < 3; r++) begin
            lsu_ready_i = 1'b0;
            for (int i = 0; i < 4; i++) begin
                push_req(32'h100 * (r + 1) + 32'(i), 1'((i + r) % 2), 1'b1);
            end
            chk("t4_full_ready", 32'(req_ready_o), 32'd0);
            chk("t4_full_count", 32'(count_o), 32'd4);
            push_req(32'hdead, 1'b1, 1'b0);
            chk("t4_fifth_dropped", 32'(count_o), 32'd4);
            lsu_ready_i = 1'b1;
            drain(12);
            chk("t4_drained_count", 32'(count_o), 32'd0);
            chk("t4_drained_ready", 32'(req_ready_o), 32'd1);
            chk("t4_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        end

        // RAW hazard
        push_req(32'hcad, 1'b0, 1'b1);
        push_req(32'hcad, 1'b1, 1'b1);
        chk("t5_store_pulse", 32'(lsu_instr_valid_o), 32'd1);
        chk("t5_store_is_load", 32'(lsu_is_load_o), 32'd0);
        tick();
        tick();
`ifdef LSU_ISSUE_RAW_CHECK_EN
        chk("t5_load_held", 32'(lsu_instr_valid_o), 32'd0);
        tick();
        tick();
        chk("t5_still_held", 32'(lsu_instr_valid_o), 32'd0);
        chk("t5_held_count", 32'(count_o), 32'd1);
        store_mem_resp_i = 1'b1;
        tick();
        store_mem_resp_i = 1'b0;
        chk("t5_release_valid", 32'(lsu_instr_valid_o), 32'd1);
        chk("t5_release_is_load", 32'(lsu_is_load_o), 32'd1);
        chk("t5_st_busy_clear", 32'(st_busy_o), 32'd0);
`else
        chk("t5_load_two_after", 32'(lsu_instr_valid_o), 32'd1);
        chk("t5_load_is_load", 32'(lsu_is_load_o), 32'd1);
        chk("t5_load_instr", lsu_instr_o, 32'hcad);
`endif
        drain(3);
        chk("t5_err_clean", 32'(err_o), 32'd0);

        // Spurious response and mid-operation reset
        store_mem_resp_i = 1'b1;
        tick();
        store_mem_resp_i = 1'b0;
        chk("t6_err_set", 32'(err_o), 32'd1);
        chk("t6_st_busy_unchanged", 32'(st_busy_o), 32'd0);
        tick();
        tick();
        chk("t6_err_sticky", 32'(err_o), 32'd1);

        push_req(32'h300, 1'b1, 1'b1);
        tick();
        chk("t6_ld_busy", 32'(ld_busy_o), 32'd1);
        lsu_ready_i = 1'b0;
        push_req(32'h301, 1'b1, 1'b0);
        push_req(32'h302, 1'b0, 1'b0);
        push_req(32'h303, 1'b1, 1'b0);
        chk("t6_count_three", 32'(count_o), 32'd3);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("t6_rst_count", 32'(count_o), 32'd0);
        chk("t6_rst_ld_busy", 32'(ld_busy_o), 32'd0);
        chk("t6_rst_err", 32'(err_o), 32'd0);
        chk("t6_rst_ready", 32'(req_ready_o), 32'd1);
        lsu_ready_i = 1'b1;
        repeat (4) tick();
        chk("t6_no_issue_after_rst", 32'(count_o), 32'd0);
        load_mem_resp_i = 1'b1;
        tick();
        load_mem_resp_i = 1'b0;
        chk("t6_late_resp_spurious", 32'(err_o), 32'd1);
        tick();
        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
